div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_if.sv | 12 +
 rtl/div_iter.sv | 66 ++++++
 2 files changed

// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and the iterative divider.
interface div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
   modport slave  (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/div_iter.sv
// div_iter: 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; divide by zero yields all zeros.
module div_iter (
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);
   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
   state_t      r_state, w_next;
   logic [64:0] r_acc, w_sh, w_step;
   logic [31:0] r_dvs, w_m1, w_m2, w_q, w_r;
   logic [32:0] w_diff;
   logic [5:0]  r_cnt;
   logic        r_sgn, r_s1, r_s2, r_ready, w_ge;
   logic [63:0] r_result;
   always_comb begin
      w_m1   = (bus.signed_div_i & bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
      w_m2   = (bus.signed_div_i & bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
      w_sh   = r_acc << 1;
      w_diff = w_sh[64:32] - {1'b0, r_dvs};
      w_ge   = w_sh[64:32] >= {1'b0, r_dvs};
      w_step = w_ge ? {w_diff, w_sh[31:1], 1'b1} : w_sh;
      // magnitudes were divided; restore signs on the final step
      w_q    = (r_sgn & (r_s1 ^ r_s2)) ? -w_step[31:0] : w_step[31:0];
      w_r    = (r_sgn & r_s1) ? -w_step[63:32] : w_step[63:32];
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         FREE:    w_next = (bus.start_i & ~bus.annul_i) ? ((bus.opdata2_i == 32'd0) ? BYZERO : ON) : FREE;
         BYZERO:  w_next = bus.annul_i ? FREE : END;
         ON:      w_next = bus.annul_i ? FREE : ((r_cnt == 6'd31) ? END : ON);
         default: w_next = bus.start_i ? END : FREE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= FREE;
         r_acc    <= '0;
         r_dvs    <= '0;
         r_cnt    <= '0;
         r_sgn    <= 1'b0;
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_ready  <= 1'b0;
         r_result <= '0;
      end else begin
         r_state  <= w_next;
         r_ready  <= w_next == END;
         r_result <= (r_state == ON && w_next == END) ? {w_r, w_q} : (w_next == END) ? r_result : 64'd0;
         if (r_state == FREE && w_next == ON) begin
            r_acc <= {33'd0, w_m1};
            r_dvs <= w_m2;
            r_sgn <= bus.signed_div_i;
            r_s1  <= bus.opdata1_i[31];
            r_s2  <= bus.opdata2_i[31];
            r_cnt <= '0;
         end else if (r_state == ON) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end
   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;
endmodule
